// File: rtl/mem_burst_responder_pkg.sv
// Constants shared by the burst responder and the cache that talks to it.
package mem_burst_responder_pkg;

    localparam int BUS_W      = 32;
    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// Word-addressed RAM: synchronous write, combinational read.
module mem_word_ram
    import mem_burst_responder_pkg::*;
#(
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_burst_responder.sv
// Line-sized memory responder: fixed latency, then a BURST-beat burst with
// mem_ready on every beat, then one idle gap cycle.
module mem_burst_responder
    import mem_burst_responder_pkg::*;
#(
    parameter int    LATENCY   = 3,
    parameter int    BURST     = LINE_WORDS,
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_r,
    input  logic             mem_w,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic [BUS_W-1:0] mem_wdata,
    output logic [BUS_W-1:0] mem_rdata,
    output logic             mem_ready,
    output logic             busy
);

    localparam int BW = $clog2(BURST);
    localparam int LW = AW - BW;

    state_t           state, state_nxt;
    logic [3:0]       lat_cnt, lat_nxt;
    logic [BW-1:0]    beat, beat_nxt;
    logic [LW-1:0]    line, line_nxt;
    logic             dir, dir_nxt;
    logic             ready_nxt, busy_nxt, rdata_load;
    logic             req_held;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [BUS_W-1:0] ram_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[BUS_W-1:AW+2], mem_addr[BW+1:0]};
    // dir=1 is a write; the operation lives only while its own request line stays high
    assign req_held = dir ? mem_w : mem_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            beat      <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_nxt;
            beat      <= beat_nxt;
            mem_ready <= ready_nxt;
            busy      <= busy_nxt;
            if (rdata_load) mem_rdata <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        line <= line_nxt;
        dir  <= dir_nxt;
    end

    // The edge closing GAP samples like IDLE, so a held request chains without an extra cycle.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        beat_nxt  = beat;
        line_nxt  = line;
        dir_nxt   = dir;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (mem_r || mem_w) begin
                    line_nxt  = mem_addr[AW+1:BW+2];
                    dir_nxt   = mem_w;
                    lat_nxt   = '0;
                    beat_nxt  = '0;
                    state_nxt = (LATENCY == 1) ? ST_BURST : ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_held) begin
                    state_nxt = ST_GAP;
                end else if (lat_cnt == 4'(LATENCY - 1)) begin
                    state_nxt = ST_BURST;
                    beat_nxt  = '0;
                end else begin
                    lat_nxt = lat_cnt + 4'd1;
                end
            end
            ST_BURST: begin
                if (!req_held || beat == BW'(BURST - 1)) state_nxt = ST_GAP;
                else                                     beat_nxt  = beat + BW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reads address the RAM with the upcoming beat so the registered data lands with mem_ready.
    always_comb begin
        ready_nxt  = (state_nxt == ST_BURST);
        busy_nxt   = (state_nxt != ST_IDLE);
        rdata_load = (state_nxt == ST_BURST) && !dir_nxt;
        ram_we     = (state == ST_BURST) && dir && mem_w;
        ram_addr   = ram_we ? {line, beat} : {line_nxt, beat_nxt};
    end

    mem_word_ram #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_wdata),
        .rdata (ram_rdata)
    );

endmodule
